// File: rtl/int_issue_queue_shift.sv
// Collapsing integer issue queue: in-order age shift, CDB wakeup,
// oldest-ready select feeding the integer issue block.
module int_issue_queue_shift #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int OPC_W  = 3,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dispatch_enable,
  output logic              dispatch_ready,
  input  logic [OPC_W-1:0]  dispatch_opcode,
  input  logic [TAG_W-1:0]  dispatch_rd_tag,
  input  logic [TAG_W-1:0]  dispatch_rs1_tag,
  input  logic [DATA_W-1:0] dispatch_rs1_data,
  input  logic              dispatch_rs1_data_val,
  input  logic [TAG_W-1:0]  dispatch_rs2_tag,
  input  logic [DATA_W-1:0] dispatch_rs2_data,
  input  logic              dispatch_rs2_data_val,
  input  logic              CDB_valid,
  input  logic [TAG_W-1:0]  CDB_tag,
  input  logic [DATA_W-1:0] CDB_data,
  output logic              issueque_ready,
  input  logic              issueblk_done,
  output logic [OPC_W-1:0]  issue_opcode,
  output logic [TAG_W-1:0]  issue_rd_tag,
  output logic [DATA_W-1:0] issue_rs1_data,
  output logic [DATA_W-1:0] issue_rs2_data,
  output logic              issueque_full,
  output logic [CNT_W-1:0]  issueque_count
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [TAG_W-1:0]  rd_tag;
    logic [TAG_W-1:0]  rs1_tag;
    logic [DATA_W-1:0] rs1_data;
    logic              rs1_val;
    logic [TAG_W-1:0]  rs2_tag;
    logic [DATA_W-1:0] rs2_data;
    logic              rs2_val;
  } entry_t;

  entry_t q  [DEPTH];
  entry_t sh [DEPTH];
  entry_t nq [DEPTH];
  entry_t din;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] issued;
  logic [DEPTH-1:0] free;
  logic [DEPTH-1:0] load;
  logic [IDX_W-1:0] sel;
  logic             any;
  logic [CNT_W-1:0] cnt;

  function automatic entry_t wake(
    input entry_t            e,
    input logic              v,
    input logic [TAG_W-1:0]  t,
    input logic [DATA_W-1:0] d
  );
    entry_t r;
    r = e;
    if (v && !e.rs1_val && e.rs1_tag == t) begin
      r.rs1_data = d;
      r.rs1_val  = 1'b1;
    end
    if (v && !e.rs2_val && e.rs2_tag == t) begin
      r.rs2_data = d;
      r.rs2_val  = 1'b1;
    end
    return r;
  endfunction

  // Highest index wins: that is the oldest ready entry.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      rdy[k] = q[k].valid & q[k].rs1_val & q[k].rs2_val;
      if (rdy[k]) begin
        sel = IDX_W'(k);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    logic c;
    c = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      issued[k] = any & issueblk_done & (sel == IDX_W'(k));
      free[k]   = ~q[k].valid | issued[k];
      c         = c | free[k];
      load[k]   = c;
    end
  end

  always_comb begin
    din.valid    = dispatch_enable;
    din.opcode   = dispatch_opcode;
    din.rd_tag   = dispatch_rd_tag;
    din.rs1_tag  = dispatch_rs1_tag;
    din.rs1_data = dispatch_rs1_data;
    din.rs1_val  = dispatch_rs1_data_val;
    din.rs2_tag  = dispatch_rs2_tag;
    din.rs2_data = dispatch_rs2_data;
    din.rs2_val  = dispatch_rs2_data_val;
  end

  // An issued entry moving up a slot arrives as a bubble.
  always_comb begin
    sh[0] = load[0] ? din : q[0];
    for (int k = 1; k < DEPTH; k++) begin
      sh[k] = q[k];
      if (load[k]) begin
        sh[k]       = q[k-1];
        sh[k].valid = q[k-1].valid & ~issued[k-1];
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      nq[k] = wake(sh[k], CDB_valid, CDB_tag, CDB_data);
      if (flush) nq[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) q[k] <= nq[k];
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) cnt = cnt + CNT_W'(q[k].valid);
  end

  assign issueque_count = cnt;
  assign issueque_full  = (cnt == CNT_W'(DEPTH));
  assign issueque_ready = any;
  assign dispatch_ready = load[0];
  assign issue_opcode   = any ? q[sel].opcode   : '0;
  assign issue_rd_tag   = any ? q[sel].rd_tag   : '0;
  assign issue_rs1_data = any ? q[sel].rs1_data : '0;
  assign issue_rs2_data = any ? q[sel].rs2_data : '0;

endmodule

// File: tb/tb_int_issue_queue_shift.sv
// Randomized bench for int_issue_queue_shift against an
// age-ordered list model of the queue.
module tb_int_issue_queue_shift;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        de;
  logic        dr;
  logic [2:0]  d_opc;
  logic [5:0]  d_rd, d_t1, d_t2;
  logic [31:0] d_d1, d_d2;
  logic        d_v1, d_v2;
  logic        cdb_v;
  logic [5:0]  cdb_t;
  logic [31:0] cdb_d;
  logic        iq_rdy;
  logic        done;
  logic [2:0]  i_opc;
  logic [5:0]  i_rd;
  logic [31:0] i_d1, i_d2;
  logic        full;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  opc;
    logic [5:0]  rd;
    logic [5:0]  t1;
    logic [31:0] d1;
    bit          v1;
    logic [5:0]  t2;
    logic [31:0] d2;
    bit          v2;
  } ment_t;

  ment_t mq[$];

  always #5 clk = ~clk;

  int_issue_queue_shift dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dispatch_enable(de), .dispatch_ready(dr),
    .dispatch_opcode(d_opc), .dispatch_rd_tag(d_rd),
    .dispatch_rs1_tag(d_t1), .dispatch_rs1_data(d_d1),
    .dispatch_rs1_data_val(d_v1),
    .dispatch_rs2_tag(d_t2), .dispatch_rs2_data(d_d2),
    .dispatch_rs2_data_val(d_v2),
    .CDB_valid(cdb_v), .CDB_tag(cdb_t), .CDB_data(cdb_d),
    .issueque_ready(iq_rdy), .issueblk_done(done),
    .issue_opcode(i_opc), .issue_rd_tag(i_rd),
    .issue_rs1_data(i_d1), .issue_rs2_data(i_d2),
    .issueque_full(full), .issueque_count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ment_t mwake(input ment_t e);
    ment_t r = e;
    if (cdb_v && !r.v1 && r.t1 == cdb_t) begin r.d1 = cdb_d; r.v1 = 1; end
    if (cdb_v && !r.v2 && r.t2 == cdb_t) begin r.d2 = cdb_d; r.v2 = 1; end
    return r;
  endfunction

  function automatic int oldest_ready();
    int s = -1;
    for (int i = mq.size()-1; i >= 0; i--)
      if (mq[i].v1 && mq[i].v2) s = i;
    return s;
  endfunction

  task automatic compare();
    int s = oldest_ready();
    bit r = (s >= 0);
    chk("count", 64'(count), 64'(mq.size()));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("ready", 64'(iq_rdy), 64'(r));
    chk("disp_rdy", 64'(dr), 64'(mq.size() < DEPTH || (r && done)));
    chk("opc", 64'(i_opc), r ? 64'(mq[s].opc) : 64'(0));
    chk("rd", 64'(i_rd), r ? 64'(mq[s].rd) : 64'(0));
    chk("rs1", 64'(i_d1), r ? 64'(mq[s].d1) : 64'(0));
    chk("rs2", 64'(i_d2), r ? 64'(mq[s].d2) : 64'(0));
  endtask

  task automatic model_edge();
    int s;
    bit iss, acc;
    ment_t n;
    if (flush) begin
      mq.delete();
      return;
    end
    s = oldest_ready();
    iss = (s >= 0) && done;
    acc = de && (mq.size() < DEPTH || iss);
    if (iss) mq.delete(s);
    foreach (mq[i]) mq[i] = mwake(mq[i]);
    if (acc) begin
      n.opc = d_opc; n.rd = d_rd;
      n.t1 = d_t1; n.d1 = d_d1; n.v1 = d_v1;
      n.t2 = d_t2; n.d2 = d_d2; n.v2 = d_v2;
      mq.push_back(mwake(n));
    end
  endtask

  task automatic step();
    #1 compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; de = 0; cdb_v = 0; done = 0;
  endtask

  task automatic disp(input logic [5:0] rd, input logic [5:0] t1,
                      input bit v1, input logic [5:0] t2, input bit v2);
    de = 1; d_opc = rd[2:0]; d_rd = rd;
    d_t1 = t1; d_d1 = {26'h0, rd} + 32'h100; d_v1 = v1;
    d_t2 = t2; d_d2 = {26'h0, rd} + 32'h200; d_v2 = v2;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    cdb_v = 1; cdb_t = t; cdb_d = d;
  endtask

  task automatic randomize_inputs();
    flush = ($urandom_range(0, 39) == 0);
    disp(6'($urandom_range(0, 63)), 6'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)));
    d_d1 = $urandom; d_d2 = $urandom;
    d_opc = 3'($urandom_range(0, 7));
    de = ($urandom_range(0, 9) < 7);
    cdb_v = $urandom_range(0, 1);
    cdb_t = 6'($urandom_range(0, 7));
    cdb_d = $urandom;
    done = ($urandom_range(0, 9) < 6);
  endtask

  initial begin
    rst_n = 0;
    idle();
    disp(0, 0, 0, 0, 0);
    de = 0;
    cdb_t = 0; cdb_d = 0;
    @(negedge clk);
    #1 compare();
    @(negedge clk);
    rst_n = 1;
    // Fill with four entries waiting on tags 5 and 6.
    for (int i = 1; i <= 4; i++) begin
      disp(6'(10 + i), 5, 0, 6, 0);
      step();
    end
    disp(6'd20, 5, 0, 6, 0);
    step();
    step();
    de = 0;
    cdb(5, 32'hAA);
    step();
    cdb(6, 32'hBB);
    step();
    cdb_v = 0;
    done = 1;
    disp(6'd21, 7, 1, 7, 1);
    step();
    step();
    // Dispatch operand captured from a same-cycle broadcast.
    idle();
    disp(6'd30, 9, 0, 3, 1);
    cdb(9, 32'h12);
    step();
    idle();
    step();
    done = 1; flush = 1; disp(6'd31, 1, 1, 1, 1);
    step();
    idle();
    step();
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      if (n == 1500) begin
        step();
        #1 rst_n = 0;
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_ready", 64'(iq_rdy), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_disp_rdy", 64'(dr), 64'(1));
        mq.delete();
        @(negedge clk);
        rst_n = 1;
      end else begin
        step();
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
